hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised pipeline hazard unit for the five-stage MIPS core with a multi-cycle multiply/divide unit (MDU). It resolves RAW hazards by forwarding into D (branch compare) and E (ALU), and inserts stalls and flushes for load-use, branch-operand and MDU hazards. It tracks one outstanding MDU operation with an internal FSM and counts stall cycles for performance monitoring. It sits beside the datapath and replaces the single-issue hazard unit.

## Interface
Parameters:
- REGW, 5, register-address width
- MDLAT, 4, MDU busy cycles; legal range 1..2^CNTW_MD-1
- CNTW_MD, 4, MDU countdown width
- CNTW, 16, stall-counter width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- rsD, rtD, rsE, rtE  in  REGW  source registers in D and E
- writeregD, writeregE, writeregM, writeregW  in  REGW  destination registers
- regwriteD, regwriteE, regwriteM, regwriteW  in  1  register-write enables
- memtoregE, memtoregM  in  1  load in E or M
- branchD, bneD, jrD  in  1  branch or jr in D
- takenD  in  1  branch or jump resolved taken in D
- mdstartD  in  1  MDU operation in D
- mdregD  in  REGW  MDU destination register
- stallclr  in  1  synchronous clear of stallcnt
- forwardaD, forwardbD  out  1  forward ALUOutM to the D compare
- forwardaE, forwardbE  out  2  E operand select: 00 register file, 01 ResultW, 10 ALUOutM
- stallF, stallD, flushE, flushD  out  1  pipeline control
- mdbusy  out  1  MDU operation outstanding
- mddone  out  1  one-cycle MDU writeback strobe, on the dedicated second regfile port
- mdreg  out  REGW  MDU destination register, valid while mdbusy
- stallcnt  out  CNTW  saturating count of stalled cycles

## Operation
- Forwarding:
  - forwardaE/forwardbE: 10 if the E source is nonzero, equals writeregM and regwriteM. Else 01 if it equals writeregW and regwriteW. Else 00. M has priority over W.
  - forwardaD/forwardbD: 1 if the D source is nonzero, equals writeregM and regwriteM.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- branchstall = (branchD|bneD|jrD) & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- MDU FSM states:
  - IDLE → BUSY when mdstartD & ~stallD: latch mdreg=mdregD and load count=MDLAT-1.
  - BUSY: decrement count each cycle. → DONE when count==0.
  - DONE: mddone=1, then → IDLE.
- mdstall is asserted for any of the following:
  - mdstartD & state≠IDLE (structural hazard; DONE also stalls)
  - state==BUSY & mdreg≠0 & (rsD==mdreg | rtD==mdreg) (RAW)
  - state==BUSY & regwriteD & writeregD==mdreg & mdreg≠0 (WAW)
- Register file writes in the first half-cycle, so no RAW or WAW stall is needed in DONE.
- stallD = lwstall | branchstall | mdstall. stallF = stallD. flushE = stallD. flushD = takenD & ~stallD.
- stallcnt:
  - stallclr has priority and sets it to 0.
  - Otherwise it increments when stallD=1 and holds at all-ones.
- No #delays. Outputs are zero-delay combinational from inputs and state.

## Timing
- Reset state: FSM IDLE, count 0, mdreg 0, stallcnt 0. Therefore mdbusy=0 and mddone=0. Pipeline-control outputs then depend on the inputs only.
- Reset asserted mid-operation abandons the MDU operation immediately; no mddone is issued.
- MDU latency: if accepted at the edge ending cycle t, mdbusy=1 in cycles t+1..t+MDLAT+1. BUSY lasts MDLAT cycles and mddone=1 in cycle t+MDLAT+1.
- MDLAT=1 gives one BUSY cycle followed by DONE.
- An MDU operation stalled in D is not accepted. It is accepted on the first cycle with stallD=0.
- Register 0 never causes forwarding or MDU stalls.
- Simultaneous stallclr and stall: the counter reads 0 after the edge.

## Structure
- Package hazard_pkg holds:
  - typedef enum mdu_state_t {IDLE, BUSY, DONE}
  - constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
- Sub-module md_tracker holds the FSM, countdown, mdreg latch, mdbusy/mddone outputs and the RAW/WAW/structural compare. The top level holds forwarding, the other stalls and stallcnt.

## Test plan
- rsE=rtE=8, writeregM=writeregW=8, regwriteM=regwriteW=1 → forwardaE=forwardbE=10. Drop regwriteM → 01. Set rsE=0 → 00.
- memtoregE=1, rtE=5, rsD=5 → stallD=stallF=flushE=1 and stallcnt increments by 1 per stalled cycle.
- branchD=1, rsD=3, regwriteE=1, writeregE=3 → stall. Next cycle writeregM=3 with memtoregM=0 → no stall and forwardaD=1.
- MDLAT=4: mdstartD with mdregD=9 accepted at cycle 0 → mdbusy cycles 1–5, mddone only in cycle 5. rsD=9 stalls in cycles 1–4, not 5. A second mdstartD stalls in cycles 1–5.
- reset pulse asynchronously in cycle 2 of BUSY → mdbusy=0 immediately and no mddone. Then hold stallD for 2^CNTW+3 cycles → stallcnt saturates at all-ones, and stallclr → 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
// The MDU tracker state and the E-stage operand select encodings live here.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mdu_state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/md_tracker.sv
// Tracks the single outstanding MDU operation: countdown, destination latch,
// and the structural/RAW/WAW stall it imposes on the instruction in D.
module md_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned REGW    = 5,
   parameter int unsigned MDLAT   = 4,
   parameter int unsigned CNTW_MD = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mdstartD,
   input  logic            stallD,
   input  logic            regwriteD,
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic [REGW-1:0] writeregD,
   input  logic [REGW-1:0] mdregD,
   output logic            mdbusy,
   output logic            mddone,
   output logic            mdstall,
   output logic [REGW-1:0] mdreg
);

   mdu_state_t         state_q;
   logic [CNTW_MD-1:0] count_q;
   logic [REGW-1:0]    mdreg_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         mdreg_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mdstartD && !stallD) begin
                  state_q <= BUSY;
                  count_q <= CNTW_MD'(MDLAT - 1);
                  mdreg_q <= mdregD;
               end
            end
            BUSY: begin
               if (count_q == '0) state_q <= DONE;
               else               count_q <= count_q - 1'b1;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   logic busy_st;
   logic reg_nz;
   logic structural;
   logic raw;
   logic waw;

   // The regfile writes in the first half-cycle, so DONE needs no RAW/WAW stall.
   always_comb begin
      busy_st    = (state_q == BUSY);
      reg_nz     = (mdreg_q != '0);
      structural = mdstartD && (state_q != IDLE);
      raw        = busy_st && reg_nz && ((rsD == mdreg_q) || (rtD == mdreg_q));
      waw        = busy_st && reg_nz && regwriteD && (writeregD == mdreg_q);
      mdstall    = structural || raw || waw;
      mdbusy     = (state_q != IDLE);
      mddone     = (state_q == DONE);
      mdreg      = mdreg_q;
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: D/E forwarding, load-use / branch / MDU stalls and
// flushes, plus a saturating stall-cycle counter for performance monitoring.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int unsigned REGW    = 5,
   parameter int unsigned MDLAT   = 4,
   parameter int unsigned CNTW_MD = 4,
   parameter int unsigned CNTW    = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rtE,
   input  logic [REGW-1:0] writeregD,
   input  logic [REGW-1:0] writeregE,
   input  logic [REGW-1:0] writeregM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwriteD,
   input  logic            regwriteE,
   input  logic            regwriteM,
   input  logic            regwriteW,
   input  logic            memtoregE,
   input  logic            memtoregM,
   input  logic            branchD,
   input  logic            bneD,
   input  logic            jrD,
   input  logic            takenD,
   input  logic            mdstartD,
   input  logic [REGW-1:0] mdregD,
   input  logic            stallclr,
   output logic            forwardaD,
   output logic            forwardbD,
   output logic [1:0]      forwardaE,
   output logic [1:0]      forwardbE,
   output logic            stallF,
   output logic            stallD,
   output logic            flushE,
   output logic            flushD,
   output logic            mdbusy,
   output logic            mddone,
   output logic [REGW-1:0] mdreg,
   output logic [CNTW-1:0] stallcnt
);

   logic lwstall;
   logic branchstall;
   logic mdstall;
   logic ctrl_d;

   function automatic logic [1:0] fwd_e(input logic [REGW-1:0] src,
                                        input logic [REGW-1:0] wm, input logic rwm,
                                        input logic [REGW-1:0] ww, input logic rww);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src != '0) begin
         if (rwm && (src == wm))      sel = FWD_M;
         else if (rww && (src == ww)) sel = FWD_W;
      end
      return sel;
   endfunction

   always_comb begin
      forwardaE = fwd_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
      forwardbE = fwd_e(rtE, writeregM, regwriteM, writeregW, regwriteW);
      forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
      forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);

      ctrl_d      = branchD || bneD || jrD;
      lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
      branchstall = ctrl_d &&
                    ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                     (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

      stallD = lwstall || branchstall || mdstall;
      stallF = stallD;
      flushE = stallD;
      flushD = takenD && !stallD;
   end

   // stallD feeds only the tracker's registered accept, so there is no comb loop.
   md_tracker #(
      .REGW    (REGW),
      .MDLAT   (MDLAT),
      .CNTW_MD (CNTW_MD)
   ) u_md_tracker (
      .clk       (clk),
      .reset     (reset),
      .mdstartD  (mdstartD),
      .stallD    (stallD),
      .regwriteD (regwriteD),
      .rsD       (rsD),
      .rtD       (rtD),
      .writeregD (writeregD),
      .mdregD    (mdregD),
      .mdbusy    (mdbusy),
      .mddone    (mddone),
      .mdstall   (mdstall),
      .mdreg     (mdreg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallcnt <= '0;
      end else if (stallclr) begin
         stallcnt <= '0;
      end else if (stallD && (stallcnt != '1)) begin
         stallcnt <= stallcnt + 1'b1;
      end
   end

endmodule
